b_sram_reader: RTL and testbench

Drains one B tile (ACC_DEPTH consecutive 264-bit words) from `b_sram` and streams it to the systolic array as MATRIX_SIZE 8-bit lanes per beat. Sits directly downstream of `b_sram`: drives its `output_en`/`addr`, absorbs its one-cycle read latency, and applies valid/ready backpressure toward the array. Optionally applies the diagonal input skew the array requires.

---
 rtl/b_sram_reader_if.sv | 24 ++
 rtl/b_sram_reader.sv | 179 +++++++++++++++++
 tb/tb_b_sram_reader.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/b_sram_reader_if.sv
// Beat stream from b_sram_reader toward the systolic array.
// The master drives b_valid/b_data/b_last. The slave (the array) drives b_ready.
interface b_sram_reader_if #(
    parameter int MATRIX_SIZE = 32
);
    logic                     b_valid;
    logic                     b_ready;
    logic [8*MATRIX_SIZE-1:0] b_data;
    logic                     b_last;

    modport master (
        output b_valid,
        output b_data,
        output b_last,
        input  b_ready
    );

    modport slave (
        input  b_valid,
        input  b_data,
        input  b_last,
        output b_ready
    );
endinterface

// File: rtl/b_sram_reader.sv
// b_sram_reader: reads one B tile of ACC_DEPTH words from b_sram and absorbs its
// one-cycle read latency through a 2-entry FIFO. It then streams the tile to the
// systolic array as MATRIX_SIZE byte lanes per beat, under valid/ready backpressure.
// Optional feature macro: B_SKEW_EN. When it is defined, lane k is delayed by k beats,
// which produces the diagonal skew the array expects. The tile then takes
// ACC_DEPTH + MATRIX_SIZE - 1 beats.
module b_sram_reader #(
    parameter int MATRIX_SIZE = 32,
    parameter int ACC_DEPTH   = 16,
    parameter int ADDR_WIDTH  = 11,
    parameter int DATA_WIDTH  = 264
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] tile_base,
    output logic                  sram_output_en,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic [DATA_WIDTH-1:0] sram_data_in,
    b_sram_reader_if.master       b,
    output logic                  busy,
    output logic                  done
);
    localparam int LANE_W = 8 * MATRIX_SIZE;
`ifdef B_SKEW_EN
    localparam int NUM_BEATS = ACC_DEPTH + MATRIX_SIZE - 1;
`else
    localparam int NUM_BEATS = ACC_DEPTH;
`endif
    localparam int BEAT_W = $clog2(NUM_BEATS + 1);
    localparam int RD_W   = $clog2(ACC_DEPTH + 1);

    localparam logic [BEAT_W-1:0] BEAT_DATA_END = BEAT_W'(ACC_DEPTH);
    localparam logic [BEAT_W-1:0] BEAT_LAST     = BEAT_W'(NUM_BEATS - 1);
    localparam logic [RD_W-1:0]   RD_LAST       = RD_W'(ACC_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t state, state_nxt;

    logic [RD_W-1:0]       rd_cnt;
    logic [BEAT_W-1:0]     beat_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  rd_vld_p1;      // a read issued last cycle returns data this cycle
    logic [LANE_W-1:0]     fifo_mem [2];
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            fifo_cnt;
    logic [2:0]            fifo_commit;
    logic                  start_acc, data_beat, beat_vld, accept, push, pop, credit_ok;
    logic [LANE_W-1:0]     head, lane_data;
    logic                  unused_hi;

    // The array only consumes the lane bytes; the upper word bits are unused.
    assign unused_hi = ^sram_data_in[DATA_WIDTH-1:LANE_W];

    assign start_acc = (state == IDLE) && start;
    assign data_beat = (beat_cnt < BEAT_DATA_END);
    assign head      = fifo_mem[rd_ptr];

    // Beats that carry a tile word need the FIFO to hold that word.
    // Flush beats carry only skew residue, so they are always valid.
    assign beat_vld  = ((state == READ) || (state == DRAIN)) &&
                       (data_beat ? (fifo_cnt != 2'd0) : 1'b1);
    assign accept    = beat_vld && b.b_ready;
    assign pop       = accept && data_beat;
    assign push      = rd_vld_p1;

    // Count the FIFO slots already claimed: occupancy plus in-flight read,
    // minus this cycle's pop. A new read is issued only while a slot is still free.
    assign fifo_commit = {1'b0, fifo_cnt} + {2'b00, rd_vld_p1} - {2'b00, pop};
    assign credit_ok   = (fifo_commit < 3'd2);

    assign sram_addr = addr_q;
    assign b.b_valid = beat_vld;
    assign b.b_data  = beat_vld ? lane_data : '0;
    assign b.b_last  = beat_vld && (beat_cnt == BEAT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the read strobe / status outputs.
    always_comb begin
        state_nxt      = state;
        sram_output_en = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = READ;
            end
            READ: begin
                busy           = 1'b1;
                sram_output_en = credit_ok;
                if (credit_ok && (rd_cnt == RD_LAST)) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (accept && (beat_cnt == BEAT_LAST)) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read address/count, beat counter, read-latency tracking and FIFO bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt    <= '0;
            beat_cnt  <= '0;
            addr_q    <= '0;
            rd_vld_p1 <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            fifo_cnt  <= 2'd0;
        end else begin
            rd_vld_p1 <= sram_output_en;
            if (start_acc) begin
                rd_cnt   <= '0;
                beat_cnt <= '0;
                addr_q   <= tile_base;
            end else begin
                if (sram_output_en) begin
                    rd_cnt <= rd_cnt + 1'b1;
                    addr_q <= addr_q + 1'b1;
                end
                if (accept) beat_cnt <= beat_cnt + 1'b1;
            end
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Capture the returned SRAM word in the cycle after its read.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= sram_data_in[LANE_W-1:0];
    end

`ifdef B_SKEW_EN
    for (genvar k = 0; k < MATRIX_SIZE; k++) begin : g_lane
        logic [7:0] lane_in;
        assign lane_in = data_beat ? head[8*k +: 8] : 8'h00;
        if (k == 0) begin : g_direct
            assign lane_data[7:0] = lane_in;
        end else if (k == 1) begin : g_one
            logic [7:0] sr;
            // One-beat delay line for lane 1; it advances only when a beat is accepted.
            always_ff @(posedge clk) begin
                if (start_acc)   sr <= 8'h00;
                else if (accept) sr <= lane_in;
            end
            assign lane_data[15:8] = sr;
        end else begin : g_multi
            logic [8*k-1:0] sr;
            // k-beat delay line for lane k; the oldest byte sits at the top.
            always_ff @(posedge clk) begin
                if (start_acc)   sr <= '0;
                else if (accept) sr <= {sr[8*k-9:0], lane_in};
            end
            assign lane_data[8*k +: 8] = sr[8*k-1 -: 8];
        end
    end
`else
    assign lane_data = head;
`endif
endmodule

// File: tb/tb_b_sram_reader.sv
// Directed bench for b_sram_reader. A behavioural b_sram with one-cycle read latency
// holds byte k of address a = (a*32 + k) & 0xFF.
// The same file covers both builds; the expected beat follows B_SKEW_EN.
module tb_b_sram_reader;
`ifdef B_SKEW_EN
    localparam int NB = 47;
`else
    localparam int NB = 16;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [10:0]  tile_base = '0;
    logic         sram_output_en;
    logic [10:0]  sram_addr;
    logic [263:0] sram_data_in = '0;
    logic         busy, done;
    int           checks = 0;
    int           errors = 0;
    logic [255:0] obs [64];

    b_sram_reader_if #(.MATRIX_SIZE(32)) bif ();

    b_sram_reader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .tile_base      (tile_base),
        .sram_output_en (sram_output_en),
        .sram_addr      (sram_addr),
        .sram_data_in   (sram_data_in),
        .b              (bif),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    function automatic logic [263:0] mk_word(input logic [10:0] a);
        logic [263:0] w;
        int v;
        w = '0;
        for (int k = 0; k < 32; k++) begin
            v = int'(a) * 32 + k;
            w[8*k +: 8] = v[7:0];
        end
        w[263:256] = 8'hA5;
        return w;
    endfunction

    function automatic logic [255:0] exp_beat(input logic [10:0] base, input int j);
        logic [255:0] r;
        logic [10:0]  a;
        int i, v;
        r = '0;
        for (int k = 0; k < 32; k++) begin
`ifdef B_SKEW_EN
            i = j - k;
`else
            i = j;
`endif
            if (i >= 0 && i < 16) begin
                a = base + i[10:0];
                v = int'(a) * 32 + k;
                r[8*k +: 8] = v[7:0];
            end
        end
        return r;
    endfunction

    // Behavioural b_sram: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (sram_output_en) sram_data_in <= mk_word(sram_addr);
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"},   256'(sram_output_en), 256'(0));
        chk({tag, "_addr"}, 256'(sram_addr),      256'(0));
        chk({tag, "_vld"},  256'(bif.b_valid),    256'(0));
        chk({tag, "_data"}, bif.b_data,           256'(0));
        chk({tag, "_last"}, 256'(bif.b_last),     256'(0));
        chk({tag, "_busy"}, 256'(busy),           256'(0));
        chk({tag, "_done"}, 256'(done),           256'(0));
    endtask

    // mode 0: b_ready held high. mode 1: b_ready toggles, with a 10-cycle stall.
    // pulse: re-pulse start at beat 4 and again in the DONE cycle.
    // rst_beat >= 0: assert reset once that many beats have been accepted.
    task automatic run_tile(input logic [10:0] base, input int mode, input bit pulse,
                            input int rst_beat);
        int j, rd, done_cnt, done_cyc, first_vld, last_acc;
        bit prev_hold, pend_start, in_stall;
        logic [10:0] ea;
        j = 0; rd = 0; done_cnt = 0; done_cyc = -1; first_vld = -1; last_acc = -1;
        prev_hold = 1'b0; pend_start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        tile_base = base;
        bif.b_ready = (mode == 0);
        for (int cyc = 1; cyc < 600; cyc++) begin
            @(posedge clk); #1;
            start = pend_start;
            if (pend_start) tile_base = 11'h155;
            pend_start = 1'b0;
            in_stall = (mode == 1) && (cyc >= 20) && (cyc < 30);
            bif.b_ready = (mode == 0) ? 1'b1 : (in_stall ? 1'b0 : (cyc % 2 == 0));
            @(negedge clk);
            if (cyc == 1) begin
                chk("busy_c1", 256'(busy), 256'(1));
                chk("en_c1", 256'(sram_output_en), 256'(1));
            end
            if (sram_output_en) begin
                ea = base + rd[10:0];
                chk("rd_addr", 256'(sram_addr), 256'(ea));
                rd++;
            end
            if (in_stall && cyc >= 23) chk("stall_en", 256'(sram_output_en), 256'(0));
            if (prev_hold) chk("vld_hold", 256'(bif.b_valid), 256'(1));
            if (!bif.b_valid) chk("idle_data", bif.b_data, 256'(0));
            if (bif.b_valid && first_vld < 0) first_vld = cyc;
            if (bif.b_valid && bif.b_ready) begin
                if (j < 64) obs[j] = bif.b_data;
                chk("beat_data", bif.b_data, exp_beat(base, j));
                chk("beat_last", 256'(bif.b_last), 256'(j == NB - 1));
                j++;
                last_acc = cyc;
                if (pulse && (j == 4 || j == NB)) pend_start = 1'b1;
            end
            prev_hold = bif.b_valid && !bif.b_ready;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                chk("busy_at_done", 256'(busy), 256'(0));
            end else if (done_cyc >= 0) begin
                chk("idle_busy", 256'(busy), 256'(0));
            end
            if (rst_beat >= 0 && j == rst_beat) break;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        if (rst_beat >= 0) begin
            chk("rst_reached", 256'(j), 256'(rst_beat));
            rst_n = 1'b0;
            #1;
            chk_all_zero("rst_mid");
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (4) begin
                @(negedge clk);
                chk("post_rst_done", 256'(done), 256'(0));
                chk("post_rst_vld", 256'(bif.b_valid), 256'(0));
            end
        end else begin
            chk("beats", 256'(j), 256'(NB));
            chk("reads", 256'(rd), 256'(16));
            chk("done_cnt", 256'(done_cnt), 256'(1));
            chk("done_cyc", 256'(done_cyc), 256'(last_acc + 1));
            if (mode == 0) begin
                chk("first_vld", 256'(first_vld), 256'(3));
                chk("no_bubble", 256'(last_acc), 256'(NB + 2));
            end
        end
    endtask

    initial begin
        bif.b_ready = 1'b0;
        #3;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("idle");

        run_tile(11'd0, 0, 1'b0, -1);
`ifdef B_SKEW_EN
        chk("b0_all", obs[0], 256'(0));
        chk("b5_l3", 256'(obs[5][31:24]), 256'(8'h43));
        chk("b46_l31", 256'(obs[46][255:248]), 256'(8'hFF));
`else
        chk("b0_l31", 256'(obs[0][255:248]), 256'(8'h1F));
        chk("b15_l0", 256'(obs[15][7:0]), 256'(8'hE0));
        chk("b15_l31", 256'(obs[15][255:248]), 256'(8'hFF));
`endif
        run_tile(11'd2045, 0, 1'b0, -1);
        run_tile(11'd0, 1, 1'b0, -1);
        run_tile(11'd0, 0, 1'b1, -1);
        run_tile(11'd0, 0, 1'b0, 7);
        run_tile(11'd0, 0, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
